// File: rtl/fwd_hazard_unit_pkg.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit_pkg
// Shared definitions for the forwarding / hazard unit:
//   - default datapath and register-address widths
//   - hazard FSM state encoding (also visible on the debug state_o port)
//   - MIPS opcode and funct constants used by the source-use decoder
// ---------------------------------------------------------------------------
package fwd_hazard_unit_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int RADDR_DEF = 5;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_FLUSH    = 2'd2
  } hazard_state_e;

  // Primary opcodes (ir[31:26])
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_SW     = 6'h2B;

  // R-type function codes (ir[5:0])
  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_SLLV    = 6'h04;
  localparam logic [5:0] FN_SRLV    = 6'h06;
  localparam logic [5:0] FN_SRAV    = 6'h07;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2A;
  localparam logic [5:0] FN_SLTU    = 6'h2B;

endpackage

// File: rtl/fwd_hazard_unit_reg_use_decode.sv
// ---------------------------------------------------------------------------
// reg_use_decode
// Tells whether an instruction actually reads its rs and/or rt field, so
// that don't-care register fields never cause a forward or a stall.
// Ports:
//   ir_i     - 32-bit instruction word
//   useRs_o  - instruction reads rs
//   useRt_o  - instruction reads rt
// ---------------------------------------------------------------------------
module reg_use_decode
  import fwd_hazard_unit_pkg::*;
(
  input  logic [31:0] ir_i,
  output logic        useRs_o,
  output logic        useRt_o
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unusedIrBits;

  assign opcode       = ir_i[31:26];
  assign funct        = ir_i[5:0];
  assign unusedIrBits = ^ir_i[25:6];

  // Constant-shift R-types only read rt; lui, j and jal read nothing.
  // All REGIMM branches (bgez/bltz) compare rs against zero.
  always_comb begin
    useRs_o = 1'b0;
    useRt_o = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU, FN_SLLV, FN_SRLV, FN_SRAV, FN_SYSCALL: begin
            useRs_o = 1'b1;
            useRt_o = 1'b1;
          end
          FN_SLL, FN_SRL, FN_SRA: useRt_o = 1'b1;
          FN_JR:                  useRs_o = 1'b1;
          default: ;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI,
      OP_LW, OP_LBU, OP_REGIMM, OP_BLEZ, OP_BGTZ: useRs_o = 1'b1;
      OP_BEQ, OP_BNE, OP_SW: begin
        useRs_o = 1'b1;
        useRt_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
// Operand forwarding plus pipeline hazard control for a 5-stage MIPS core.
//   - ex_r1/ex_r2: combinational forward, MEM ALU result beats WB data
//   - load-use: one bubble (hold PC and IF/ID, flush ID/EX)
//   - data-memory wait: MEM_WAIT state holds PC, IF/ID, ID/EX, EX/MEM
//   - taken branch: flush IF/ID and ID/EX, then one FLUSH cycle
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   id_ir/ex_ir, *_ra/*_rb      ID/EX instructions and source registers
//   *_rw, *_regwrite, *_memread destination/write/load flags per stage
//   ex_r*_ori, mem_alu, wb_din  candidate operand values
//   mem_ready, branch_taken     memory completion, branch resolution
//   ex_r1, ex_r2                forwarded operands
//   *_stall, *_flush            pipeline register control
//   state_o                     FSM state (debug)
// Optional build macro HAZARD_STATS_EN adds saturating counters
//   stall_cycles (cycles with pc_stall) and flush_count (accepted branches).
// ---------------------------------------------------------------------------
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int RADDR = RADDR_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      id_ir,
  input  logic [31:0]      ex_ir,
  input  logic [RADDR-1:0] id_ra,
  input  logic [RADDR-1:0] id_rb,
  input  logic [RADDR-1:0] ex_ra,
  input  logic [RADDR-1:0] ex_rb,
  input  logic [RADDR-1:0] ex_rw,
  input  logic [RADDR-1:0] mem_rw,
  input  logic [RADDR-1:0] wb_rw,
  input  logic             ex_regwrite,
  input  logic             mem_regwrite,
  input  logic             wb_regwrite,
  input  logic             ex_memread,
  input  logic             mem_memread,
  input  logic [XLEN-1:0]  ex_r1_ori,
  input  logic [XLEN-1:0]  ex_r2_ori,
  input  logic [XLEN-1:0]  mem_alu,
  input  logic [XLEN-1:0]  wb_din,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic [XLEN-1:0]  ex_r1,
  output logic [XLEN-1:0]  ex_r2,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_stall,
  output logic             exmem_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       state_o
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
`endif
);

  logic          idUseRs, idUseRt, exUseRs, exUseRt;
  logic          loadUse, memWait, branchReq, branchAccept;
  logic          pcStall, ifidStall, idexStall, exmemStall, ifidFlush, idexFlush;
  logic          pendBranch_q, pendBranch_d;
  hazard_state_e state_q, state_d;

  reg_use_decode uIdDec (.ir_i(id_ir), .useRs_o(idUseRs), .useRt_o(idUseRt));
  reg_use_decode uExDec (.ir_i(ex_ir), .useRs_o(exUseRs), .useRt_o(exUseRt));

  // A load result is not in mem_alu, so a load in MEM never forwards from MEM.
  function automatic logic [XLEN-1:0] fwdSel(input logic used,
                                             input logic [RADDR-1:0] src,
                                             input logic [XLEN-1:0] ori);
    logic live;
    live = used && (src != '0);
    if (live && mem_regwrite && !mem_memread && (src == mem_rw)) return mem_alu;
    if (live && wb_regwrite && (src == wb_rw))                    return wb_din;
    return ori;
  endfunction

  assign ex_r1 = fwdSel(exUseRs, ex_ra, ex_r1_ori);
  assign ex_r2 = fwdSel(exUseRt, ex_rb, ex_r2_ori);

  assign loadUse = ex_memread && ex_regwrite && (ex_rw != '0) &&
                   ((idUseRs && (id_ra == ex_rw)) || (idUseRt && (id_rb == ex_rw)));
  assign memWait   = mem_memread && !mem_ready;
  assign branchReq = branch_taken || pendBranch_q;

  // State register and the deferred-branch flag; reset abandons any wait
  // or flush in progress and forgets a branch seen during a memory wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_RUN;
      pendBranch_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pendBranch_q <= pendBranch_d;
    end
  end

  // Next state and control outputs. A memory wait starting in RUN wins over
  // a branch, which is then remembered and taken in the first RUN cycle
  // after the wait ends, exactly like a fresh branch_taken.
  always_comb begin
    state_d      = state_q;
    pendBranch_d = pendBranch_q;
    branchAccept = 1'b0;
    pcStall      = 1'b0;
    ifidStall    = 1'b0;
    idexStall    = 1'b0;
    exmemStall   = 1'b0;
    ifidFlush    = 1'b0;
    idexFlush    = 1'b0;
    case (state_q)
      S_RUN: begin
        if (memWait) begin
          state_d      = S_MEM_WAIT;
          pendBranch_d = pendBranch_q || branch_taken;
        end else if (branchReq) begin
          ifidFlush    = 1'b1;
          idexFlush    = 1'b1;
          branchAccept = 1'b1;
          pendBranch_d = 1'b0;
          state_d      = S_FLUSH;
        end else if (loadUse) begin
          pcStall   = 1'b1;
          ifidStall = 1'b1;
          idexFlush = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        pcStall      = 1'b1;
        ifidStall    = 1'b1;
        idexStall    = 1'b1;
        exmemStall   = 1'b1;
        pendBranch_d = pendBranch_q || branch_taken;
        if (mem_ready) state_d = S_RUN;
      end
      S_FLUSH: begin
        idexFlush = 1'b1;
        state_d   = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  // Controls are forced low while reset is held, independent of inputs.
  assign pc_stall    = rst_n && pcStall;
  assign ifid_stall  = rst_n && ifidStall;
  assign idex_stall  = rst_n && idexStall;
  assign exmem_stall = rst_n && exmemStall;
  assign ifid_flush  = rst_n && ifidFlush;
  assign idex_flush  = rst_n && idexFlush;
  assign state_o     = state_q;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stallCycles_q, flushCount_q;

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCycles_q <= '0;
      flushCount_q  <= '0;
    end else begin
      if (pcStall && (stallCycles_q != '1)) stallCycles_q <= stallCycles_q + CNT_W'(1);
      if (branchAccept && (flushCount_q != '1)) flushCount_q <= flushCount_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stallCycles_q;
  assign flush_count  = flushCount_q;
`else
  localparam int unusedCntW = CNT_W;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_fwd_hazard_unit
// Directed scenarios for forwarding, load-use, memory wait, deferred branch
// and reset, followed by randomized cycles checked against a behavioural
// model of the forwarding priorities and the hazard state rules.
// ---------------------------------------------------------------------------
module tb_fwd_hazard_unit;

  localparam int XLEN  = 32;
  localparam int RADDR = 5;
  localparam int CNT_W = 16;

  logic             clk, rst_n;
  logic [31:0]      id_ir, ex_ir;
  logic [RADDR-1:0] id_ra, id_rb, ex_ra, ex_rb, ex_rw, mem_rw, wb_rw;
  logic             ex_regwrite, mem_regwrite, wb_regwrite, ex_memread, mem_memread;
  logic [XLEN-1:0]  ex_r1_ori, ex_r2_ori, mem_alu, wb_din;
  logic             mem_ready, branch_taken;
  logic [XLEN-1:0]  ex_r1, ex_r2;
  logic             pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush;
  logic [1:0]       state_o;
`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cycles, flush_count;
`endif

  logic [5:0] ctrlObs;
  assign ctrlObs = {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush};

  int assertCount = 0;
  int failCount   = 0;
  int mState      = 0;
  bit mPend       = 1'b0;

  fwd_hazard_unit #(.XLEN(XLEN), .RADDR(RADDR), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_ir(id_ir), .ex_ir(ex_ir),
    .id_ra(id_ra), .id_rb(id_rb), .ex_ra(ex_ra), .ex_rb(ex_rb),
    .ex_rw(ex_rw), .mem_rw(mem_rw), .wb_rw(wb_rw),
    .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
    .ex_memread(ex_memread), .mem_memread(mem_memread),
    .ex_r1_ori(ex_r1_ori), .ex_r2_ori(ex_r2_ori), .mem_alu(mem_alu), .wb_din(wb_din),
    .mem_ready(mem_ready), .branch_taken(branch_taken),
    .ex_r1(ex_r1), .ex_r2(ex_r2),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
    .exmem_stall(exmem_stall), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .state_o(state_o)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction builders
  function automatic logic [31:0] rInstr(input logic [5:0] fn, input int rs, input int rt, input int rd);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] iInstr(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] randInstr(input int kind, input int rs, input int rt);
    case (kind)
      0:  return rInstr(6'h20, rs, rt, 7);        // add
      1:  return rInstr(6'h00, 0, rt, 7);         // sll
      2:  return rInstr(6'h08, rs, 0, 0);         // jr
      3:  return rInstr(6'h0C, 0, 0, 0);          // syscall
      4:  return rInstr(6'h2A, rs, rt, 7);        // slt
      5:  return iInstr(6'h08, rs, rt, 16'h4);    // addi
      6:  return iInstr(6'h0F, 0, rt, 16'h1234);  // lui
      7:  return iInstr(6'h04, rs, rt, 16'h8);    // beq
      8:  return iInstr(6'h01, rs, 1, 16'h8);     // bgez
      9:  return iInstr(6'h23, rs, rt, 16'h0);    // lw
      10: return iInstr(6'h2B, rs, rt, 16'h0);    // sw
      11: return iInstr(6'h24, rs, rt, 16'h0);    // lbu
      12: return {6'h02, 26'h40};                 // j
      default: return iInstr(6'h06, rs, 0, 16'h8); // blez
    endcase
  endfunction

  // Which sources an instruction reads: bit0 = rs, bit1 = rt
  function automatic logic [1:0] srcUse(input logic [31:0] ir);
    logic [5:0] op, fn;
    op = ir[31:26];
    fn = ir[5:0];
    if (op == 6'h00) begin
      if (fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                     6'h2A, 6'h2B, 6'h04, 6'h06, 6'h07, 6'h0C}) return 2'b11;
      if (fn inside {6'h00, 6'h02, 6'h03}) return 2'b10;
      if (fn == 6'h08) return 2'b01;
      return 2'b00;
    end
    if (op inside {6'h04, 6'h05, 6'h2B}) return 2'b11;
    if (op inside {6'h01, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
                   6'h0D, 6'h0E, 6'h23, 6'h24}) return 2'b01;
    return 2'b00;
  endfunction

  // Expected operand: newest non-load producer of a live source register
  function automatic logic [XLEN-1:0] fwdModel(input bit used, input logic [RADDR-1:0] src,
                                               input logic [XLEN-1:0] ori);
    if (!used || src == 0) return ori;
    if (mem_regwrite && !mem_memread && mem_rw == src) return mem_alu;
    if (wb_regwrite && wb_rw == src) return wb_din;
    return ori;
  endfunction

  // Expected controls for the current cycle and the mode after the next edge
  task automatic modelEval(output logic [5:0] ctrl, output int nState, output bit nPend);
    logic [1:0] idUse;
    bit lu;
    ctrl   = 6'b0;
    nState = mState;
    nPend  = mPend;
    if (!rst_n) begin
      nState = 0;
      nPend  = 1'b0;
      return;
    end
    idUse = srcUse(id_ir);
    lu = ex_memread && ex_regwrite && ex_rw != 0 &&
         ((idUse[0] && id_ra == ex_rw) || (idUse[1] && id_rb == ex_rw));
    if (mState == 1) begin
      ctrl  = 6'b111100;
      nPend = mPend || branch_taken;
      if (mem_ready) nState = 0;
    end else if (mState == 2) begin
      ctrl   = 6'b000001;
      nState = 0;
    end else if (mem_memread && !mem_ready) begin
      nState = 1;
      nPend  = mPend || branch_taken;
    end else if (branch_taken || mPend) begin
      ctrl   = 6'b000011;
      nState = 2;
      nPend  = 1'b0;
    end else if (lu) begin
      ctrl = 6'b110001;
    end
  endtask

  task automatic applyIdle();
    id_ir = 32'h0; ex_ir = 32'h0;
    id_ra = '0; id_rb = '0; ex_ra = '0; ex_rb = '0;
    ex_rw = '0; mem_rw = '0; wb_rw = '0;
    ex_regwrite = 0; mem_regwrite = 0; wb_regwrite = 0;
    ex_memread = 0; mem_memread = 0;
    ex_r1_ori = 32'h1111_1111; ex_r2_ori = 32'h2222_2222;
    mem_alu = 32'h0; wb_din = 32'h0;
    mem_ready = 1; branch_taken = 0;
  endtask

  task automatic test_reset();
    applyIdle();
    rst_n = 0;
    branch_taken = 1; mem_memread = 1; mem_ready = 0;
    ex_memread = 1; ex_regwrite = 1; ex_rw = 5'd2;
    id_ir = rInstr(6'h20, 2, 1, 6); id_ra = 5'd2; id_rb = 5'd1;
    ex_ir = rInstr(6'h20, 3, 3, 4); ex_ra = 5'd3; ex_rb = 5'd3;
    wb_rw = 5'd3; wb_regwrite = 1; wb_din = 32'h77;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    assertCount++;
    if (ctrlObs !== 6'b0) begin failCount++; $display("[TB] FAIL reset_ctrl: got %b expected %b", ctrlObs, 6'b0); end
    assertCount++;
    if (state_o !== 2'd0) begin failCount++; $display("[TB] FAIL reset_state: got %0d expected 0", state_o); end
    assertCount++;
    if (ex_r1 !== 32'h77) begin failCount++; $display("[TB] FAIL reset_fwd: got %h expected %h", ex_r1, 32'h77); end
    @(negedge clk);
    applyIdle();
    rst_n = 1;
    #1;
    assertCount++;
    if (ctrlObs !== 6'b0 || state_o !== 2'd0) begin
      failCount++; $display("[TB] FAIL reset_release: got ctrl %b state %0d expected 0/0", ctrlObs, state_o);
    end
  endtask

  task automatic test_forward();
    @(negedge clk);
    applyIdle();
    ex_ir = rInstr(6'h20, 3, 3, 4); ex_ra = 5'd3; ex_rb = 5'd3;
    mem_rw = 5'd3; mem_regwrite = 1; mem_alu = 32'h10;
    #1;
    assertCount++;
    if (ex_r1 !== 32'h10) begin failCount++; $display("[TB] FAIL fwd_mem_r1: got %h expected %h", ex_r1, 32'h10); end
    assertCount++;
    if (ex_r2 !== 32'h10) begin failCount++; $display("[TB] FAIL fwd_mem_r2: got %h expected %h", ex_r2, 32'h10); end
    ex_ir = rInstr(6'h20, 5, 5, 6); ex_ra = 5'd5; ex_rb = 5'd5;
    mem_rw = 5'd5; wb_rw = 5'd5; wb_regwrite = 1; mem_alu = 32'hA; wb_din = 32'hB;
    #1;
    assertCount++;
    if (ex_r1 !== 32'hA) begin failCount++; $display("[TB] FAIL fwd_mem_beats_wb: got %h expected %h", ex_r1, 32'hA); end
    mem_rw = 5'd0;
    #1;
    assertCount++;
    if (ex_r1 !== 32'hB) begin failCount++; $display("[TB] FAIL fwd_wb: got %h expected %h", ex_r1, 32'hB); end
    mem_rw = 5'd5; mem_memread = 1;
    #1;
    assertCount++;
    if (ex_r1 !== 32'hB) begin failCount++; $display("[TB] FAIL fwd_load_in_mem: got %h expected %h", ex_r1, 32'hB); end
    mem_memread = 0;
    ex_ir = rInstr(6'h20, 0, 5, 6); ex_ra = 5'd0; mem_rw = 5'd0; wb_rw = 5'd0;
    #1;
    assertCount++;
    if (ex_r1 !== 32'h1111_1111) begin failCount++; $display("[TB] FAIL fwd_reg0: got %h expected %h", ex_r1, 32'h1111_1111); end
    ex_ir = iInstr(6'h08, 4, 5, 16'h3); ex_ra = 5'd4; ex_rb = 5'd5; mem_rw = 5'd5;
    #1;
    assertCount++;
    if (ex_r2 !== 32'h2222_2222) begin failCount++; $display("[TB] FAIL fwd_unused_rt: got %h expected %h", ex_r2, 32'h2222_2222); end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    applyIdle();
    ex_ir = iInstr(6'h23, 1, 2, 16'h0); ex_rw = 5'd2; ex_memread = 1; ex_regwrite = 1;
    id_ir = rInstr(6'h20, 2, 1, 6); id_ra = 5'd2; id_rb = 5'd1;
    #1;
    assertCount++;
    if (ctrlObs !== 6'b110001) begin failCount++; $display("[TB] FAIL load_use_bubble: got %b expected %b", ctrlObs, 6'b110001); end
    @(negedge clk);
    ex_ir = 32'h0; ex_rw = '0; ex_memread = 0; ex_regwrite = 0;
    mem_rw = 5'd2; mem_regwrite = 1; mem_memread = 1; mem_ready = 1;
    #1;
    assertCount++;
    if (ctrlObs !== 6'b0) begin failCount++; $display("[TB] FAIL load_use_one_cycle: got %b expected %b", ctrlObs, 6'b0); end
    @(negedge clk);
    applyIdle();
    ex_ir = iInstr(6'h23, 1, 2, 16'h0); ex_rw = 5'd2; ex_memread = 1; ex_regwrite = 1;
    id_ir = iInstr(6'h08, 3, 2, 16'h5); id_ra = 5'd3; id_rb = 5'd2;
    #1;
    assertCount++;
    if (ctrlObs !== 6'b0) begin failCount++; $display("[TB] FAIL load_use_unused_src: got %b expected %b", ctrlObs, 6'b0); end
  endtask

  task automatic test_mem_wait();
    @(negedge clk);
    applyIdle();
    mem_memread = 1; mem_ready = 0;
    #1;
    assertCount++;
    if (state_o !== 2'd0 || ctrlObs !== 6'b0) begin
      failCount++; $display("[TB] FAIL wait_entry: got state %0d ctrl %b expected 0/000000", state_o, ctrlObs);
    end
    ex_ir = iInstr(6'h23, 1, 2, 16'h0); ex_rw = 5'd2; ex_memread = 1; ex_regwrite = 1;
    id_ir = rInstr(6'h20, 2, 1, 6); id_ra = 5'd2; id_rb = 5'd1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 2) mem_ready = 1;
      #1;
      assertCount++;
      if (state_o !== 2'd1 || ctrlObs !== 6'b111100) begin
        failCount++; $display("[TB] FAIL wait_cycle%0d: got state %0d ctrl %b expected 1/111100", c, state_o, ctrlObs);
      end
    end
    @(negedge clk);
    applyIdle();
    #1;
    assertCount++;
    if (state_o !== 2'd0 || ctrlObs !== 6'b0) begin
      failCount++; $display("[TB] FAIL wait_exit: got state %0d ctrl %b expected 0/000000", state_o, ctrlObs);
    end
  endtask

  task automatic test_branch_wait_reset();
    logic [1:0] expState [0:5] = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd2, 2'd0};
    logic [5:0] expCtrl  [0:5] = '{6'b111100, 6'b111100, 6'b111100, 6'b000011, 6'b000001, 6'b000000};
    @(negedge clk);
    applyIdle();
    mem_memread = 1; mem_ready = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      branch_taken = (c == 0);
      if (c == 2) mem_ready = 1;
      if (c == 3) mem_memread = 0;
      #1;
      assertCount++;
      if (state_o !== expState[c] || ctrlObs !== expCtrl[c]) begin
        failCount++;
        $display("[TB] FAIL deferred_branch_c%0d: got state %0d ctrl %b expected %0d/%b", c, state_o, ctrlObs, expState[c], expCtrl[c]);
      end
    end
    @(negedge clk);
    branch_taken = 1;
    #1;
    assertCount++;
    if (ctrlObs !== 6'b000011) begin failCount++; $display("[TB] FAIL branch_flush: got %b expected %b", ctrlObs, 6'b000011); end
    @(negedge clk);
    branch_taken = 0;
    #1;
    assertCount++;
    if (state_o !== 2'd2 || ctrlObs !== 6'b000001) begin
      failCount++; $display("[TB] FAIL flush_state: got state %0d ctrl %b expected 2/000001", state_o, ctrlObs);
    end
    rst_n = 0;
    #1;
    assertCount++;
    if (state_o !== 2'd0 || ctrlObs !== 6'b0) begin
      failCount++; $display("[TB] FAIL reset_mid_flush: got state %0d ctrl %b expected 0/000000", state_o, ctrlObs);
    end
    @(negedge clk);
    rst_n = 1;
    #1;
    assertCount++;
    if (state_o !== 2'd0 || ctrlObs !== 6'b0) begin
      failCount++; $display("[TB] FAIL after_reset_run: got state %0d ctrl %b expected 0/000000", state_o, ctrlObs);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] expState [0:3] = '{2'd0, 2'd2, 2'd0, 2'd2};
    logic [5:0] expCtrl  [0:3] = '{6'b000011, 6'b000001, 6'b000011, 6'b000001};
    @(negedge clk);
    applyIdle();
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      branch_taken = (c < 3);
      #1;
      assertCount++;
      if (state_o !== expState[c] || ctrlObs !== expCtrl[c]) begin
        failCount++;
        $display("[TB] FAIL back_to_back_c%0d: got state %0d ctrl %b expected %0d/%b", c, state_o, ctrlObs, expState[c], expCtrl[c]);
      end
    end
    @(negedge clk);
    applyIdle();
  endtask

  task automatic test_random();
    logic [5:0]      eCtrl;
    logic [XLEN-1:0] eR1, eR2;
    logic [1:0]      exUse;
    int              nState;
    bit              nPend;
    @(negedge clk);
    applyIdle();
    rst_n = 0;
    mState = 0; mPend = 0;
    @(negedge clk);
    rst_n = 1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 59) != 0);
      if (!rst_n) begin mState = 0; mPend = 0; end
      id_ir = randInstr($urandom_range(0, 13), $urandom_range(0, 3), $urandom_range(0, 3));
      ex_ir = randInstr($urandom_range(0, 13), $urandom_range(0, 3), $urandom_range(0, 3));
      id_ra = 5'($urandom_range(0, 3)); id_rb = 5'($urandom_range(0, 3));
      ex_ra = 5'($urandom_range(0, 3)); ex_rb = 5'($urandom_range(0, 3));
      ex_rw = 5'($urandom_range(0, 3)); mem_rw = 5'($urandom_range(0, 3)); wb_rw = 5'($urandom_range(0, 3));
      ex_regwrite  = ($urandom_range(0, 3) != 0);
      mem_regwrite = ($urandom_range(0, 3) != 0);
      wb_regwrite  = ($urandom_range(0, 3) != 0);
      ex_memread   = ($urandom_range(0, 2) == 0);
      mem_memread  = ($urandom_range(0, 2) == 0);
      mem_ready    = ($urandom_range(0, 4) < 3);
      branch_taken = ($urandom_range(0, 6) == 0);
      ex_r1_ori = $urandom; ex_r2_ori = $urandom; mem_alu = $urandom; wb_din = $urandom;
      #1;
      exUse = srcUse(ex_ir);
      eR1 = fwdModel(exUse[0], ex_ra, ex_r1_ori);
      eR2 = fwdModel(exUse[1], ex_rb, ex_r2_ori);
      modelEval(eCtrl, nState, nPend);
      assertCount++;
      if (ex_r1 !== eR1) begin failCount++; $display("[TB] FAIL rand_r1 n=%0d: got %h expected %h", n, ex_r1, eR1); end
      assertCount++;
      if (ex_r2 !== eR2) begin failCount++; $display("[TB] FAIL rand_r2 n=%0d: got %h expected %h", n, ex_r2, eR2); end
      assertCount++;
      if (ctrlObs !== eCtrl) begin failCount++; $display("[TB] FAIL rand_ctrl n=%0d: got %b expected %b", n, ctrlObs, eCtrl); end
      assertCount++;
      if (state_o !== 2'(mState)) begin failCount++; $display("[TB] FAIL rand_state n=%0d: got %0d expected %0d", n, state_o, mState); end
      @(posedge clk);
      mState = nState;
      mPend  = nPend;
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_mem_wait();
    test_branch_wait_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter RADDR, default 5, register-address width; register 0 hardwired zero.
REQ-003 SHALL have parameter CNT_W, default 16, statistics counter width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 id_ir, ex_ir  input  32  instructions in ID and EX; source-use decode.
REQ-007 id_ra, id_rb, ex_ra, ex_rb  input  RADDR  source register numbers in ID and EX.
REQ-008 ex_rw, mem_rw, wb_rw  input  RADDR  destination registers per stage.
REQ-009 ex_regwrite, mem_regwrite, wb_regwrite  input  1  stage writes a register.
REQ-010 ex_memread, mem_memread  input  1  stage holds a load.
REQ-011 ex_r1_ori, ex_r2_ori  input  XLEN  register-file operands latched in ID/EX.
REQ-012 mem_alu, wb_din  input  XLEN  MEM ALU result; WB write-back data.
REQ-013 mem_ready  input  1  data memory completes the access held in MEM.
REQ-014 branch_taken  input  1  EX resolves a taken branch/jump.
REQ-015 ex_r1, ex_r2  output  XLEN  forwarded operands.
REQ-016 pc_stall, ifid_stall, idex_stall, exmem_stall  output  1  hold the named register.
REQ-017 ifid_flush, idex_flush  output  1  insert bubble into the named register.
REQ-018 state_o  output  2  current FSM state, debug.

Function
REQ-019 Source-use SHALL be decoded per instruction (R-type ALU/shift/jr/syscall, I-type ALU, branches, lw/sw/lbu, bgez/bltz); a source not used never forwards or stalls.
REQ-020 Operand n SHALL select mem_alu when MEM hits (match, nonzero, used, mem_regwrite, !mem_memread), else wb_din when WB hits, else ex_rn_ori; MEM beats WB.
REQ-021 Load-use: in RUN, ex_memread && ex_regwrite && ex_rw!=0 && ex_rw matching a used ID source SHALL assert pc_stall, ifid_stall, idex_flush that cycle only (one bubble).
REQ-022 FSM states RUN(0), MEM_WAIT(1), FLUSH(2).
REQ-023 RUN->MEM_WAIT when mem_memread && !mem_ready; MEM_WAIT holds until mem_ready=1, then ->RUN.
REQ-024 In MEM_WAIT, pc_stall, ifid_stall, idex_stall, exmem_stall SHALL be 1; no flush, no load-use bubble.
REQ-025 RUN->FLUSH on branch_taken; in that cycle ifid_flush=idex_flush=1 and load-use stall suppressed.
REQ-026 FLUSH SHALL last exactly one cycle, keep idex_flush=1, then ->RUN.
REQ-027 Priority: memory wait > branch flush > load-use; branch_taken during MEM_WAIT SHALL be registered and applied on MEM_WAIT exit.
REQ-028 Forwarding is combinational, zero latency, in all states.

Reset
REQ-029 rst_n=0 SHALL immediately force RUN, clear the pending branch and all stall/flush outputs to 0; ex_r1/ex_r2 follow REQ-020.
REQ-030 Reset during MEM_WAIT or FLUSH SHALL abandon the operation; first cycle after release is RUN.

Configuration
REQ-031 Macro HAZARD_STATS_EN SHALL add outputs stall_cycles and flush_count (CNT_W each), reset to 0, saturating at all-ones.
REQ-032 With it, stall_cycles increments each cycle pc_stall=1; flush_count increments per branch_taken acceptance.
REQ-033 Without it, neither port nor counter logic exists.

Structure
REQ-034 Shared package SHALL hold the FSM state enum, opcode/funct constants and the XLEN/RADDR defaults.
REQ-035 Source-use decode SHALL be sub-module reg_use_decode, instantiated for ID and EX.

Verification
REQ-036 add $3 in MEM (mem_alu=0x10), add $4,$3,$3 in EX -> ex_r1=ex_r2=0x10.
REQ-037 mem_rw=wb_rw=5, mem_alu=0xA, wb_din=0xB, EX reads $5 -> 0xA; mem_rw=0 -> 0xB; rs=$0 -> ex_r1_ori.
REQ-038 lw $2 in EX, add $6,$2,$1 in ID -> pc_stall=ifid_stall=idex_flush=1 for exactly 1 cycle.
REQ-039 lw in MEM, mem_ready low 3 cycles -> state_o=1 and all four stalls high 3 cycles, RUN next.
REQ-040 branch_taken during MEM_WAIT -> flushes deferred to exit, FLUSH 1 cycle; rst_n low mid-FLUSH -> outputs 0, RUN.
